trap_ctrl: RTL and testbench
============================

# trap_ctrl

Trap sequencer on the other side of the CSR file's exception/interrupt write ports. Detects `ecall`, `mret` and (optionally) machine timer interrupts at instruction boundaries, sequences the mepc/mcause/mstatus write strobes into the CSR file, and redirects the fetch PC to mtvec or mepc through a valid/ready handshake. Sits between IDU/EXU (trap requests) and IFU (redirect).

## Interface
- `ECALL_CAUSE`, default 11, mcause value for an M-mode ecall.
- `IRQ_CAUSE`, default 7, interrupt code for the timer interrupt; mcause = {1'b1, IRQ_CAUSE[`CPU_WIDTH-2:0]}.
- `i_clk` in 1: clock.
- `i_rst_n` in 1: reset. One clock; reset is asynchronous and active-low.
- `i_valid` in 1: an instruction is at the commit boundary this cycle.
- `i_pc` in `CPU_WIDTH: PC of that instruction.
- `i_ecall` in 1: the instruction is ecall. Qualified by `i_valid`.
- `i_mret` in 1: the instruction is mret. Qualified by `i_valid`.
- `i_irq` in 1: level timer interrupt request.
- `i_mtvec` in `CPU_WIDTH: current mtvec from the CSR file.
- `i_mepc` in `CPU_WIDTH: current mepc from the CSR file.
- `i_mstatus` in `CPU_WIDTH: current mstatus from the CSR file.
- `o_take` out 1: combinational; the instruction at `i_valid` is consumed by a trap/mret. An interrupted instruction must not write back.
- `o_busy` out 1: sequencer not idle; the pipeline must hold `i_valid` low.
- `o_mepc_wen` / `o_mepc_wdata` out 1 / `CPU_WIDTH: mepc write.
- `o_mcause_wen` / `o_mcause_wdata` out 1 / `CPU_WIDTH: mcause write.
- `o_mstatus_wen` / `o_mstatus_wdata` out 1 / `CPU_WIDTH: mstatus write.
- `o_redir_valid` out 1: redirect request to IFU.
- `o_redir_pc` out `CPU_WIDTH: redirect target.
- `i_redir_ready` in 1: IFU accepts the redirect.

## Operation
- States: IDLE, WB, REDIR. Reset state IDLE.
- IDLE: event accepted only when `i_valid`. Priority: interrupt (`i_irq & i_mstatus[3]`) > ecall > mret. If an event is accepted, `o_take`=1, kind, `i_pc` and the target are registered, and the FSM moves to WB. Otherwise `o_take`=0 and the FSM stays in IDLE.
- Targets:
  - trap target = {i_mtvec[`CPU_WIDTH-1:2], 2'b00} (direct mode only; mtvec[1:0] ignored).
  - mret target = i_mepc, sampled at acceptance.
- WB, exactly one cycle. Strobes are high only in this state.
  - Trap: mepc ← captured pc. For an interrupt this is the PC of the squashed instruction. For an ecall it is the ecall PC.
  - Trap: mcause ← ECALL_CAUSE or the IRQ encoding.
  - Trap: mstatus ← i_mstatus with MPIE[7]=MIE[3], MIE[3]=0, MPP[12:11]=2'b11.
  - mret: only mstatus ← i_mstatus with MIE[3]=MPIE[7], MPIE[7]=1, MPP[12:11]=2'b11. mepc/mcause wen stay 0.
  - mstatus wdata is computed from `i_mstatus` in the WB cycle.
- REDIR: `o_redir_valid`=1 with `o_redir_pc` = captured target. Both are held stable until `i_redir_ready`. On the handshake cycle the FSM returns to IDLE.
- `o_busy` = (state != IDLE).
- While busy: `i_valid`, `i_ecall`, `i_mret` and `i_irq` are ignored. A change in `i_irq` after acceptance has no effect.
- `i_irq` high while MIE=0: not taken. It is taken on the first `i_valid` cycle after MIE becomes 1 (e.g. after mret's WB).
- `i_ecall & i_mret` together (illegal decode): ecall wins.

## Timing
- Acceptance in cycle N (combinational `o_take`).
- Write strobes in N+1, so the CSR file holds the new values from N+2.
- `o_redir_valid` rises in N+2. Earliest return to IDLE is end of N+2. Minimum occupancy is 2 cycles after acceptance.
- Back-to-back: a new event can be accepted in the cycle after the redirect handshake.
- Reset values: all outputs 0, state IDLE, captured registers 0.
- Reset asserted mid-sequence aborts immediately: strobes and `o_redir_valid` drop asynchronously, and no partial write completes after reset.

## Configuration
- `TRAP_IRQ_EN` defined: interrupt path compiled in as above.
- `TRAP_IRQ_EN` undefined: `i_irq` is unused, only ecall/mret are recognised, and the mcause MSB is always 0.

## Test plan
- Ecall: mtvec=0x8000_0103, mstatus=0x0000_0008, ecall at pc=0x8000_0040.
  - `o_take`=1 in N.
  - N+1: mepc=0x8000_0040, mcause=11, mstatus=0x0000_1880.
  - N+2: redirect valid to 0x8000_0100.
- Mret: mepc=0x8000_0044, mstatus=0x0000_1880.
  - N+1: mstatus=0x0000_1888, with no mepc/mcause strobes.
  - N+2: redirect valid to 0x8000_0044.
- Interrupt with MIE=1: irq=1 while an ecall is at pc=0x8000_0050.
  - Interrupt wins.
  - mcause=0x8000_0007, mepc=0x8000_0050.
- Interrupt with MIE=0: irq=1 for 10 valid cycles → `o_take`=0 and no strobes.
  - After mret restores MIE=1, the next `i_valid` takes the interrupt.
- IFU backpressure: `i_redir_ready` held low 5 cycles.
  - Valid and pc stay stable and `o_busy`=1.
  - `i_valid` ecall pulses are ignored.
  - Return to IDLE after ready.
- Reset in WB and in REDIR: all outputs 0 and state IDLE immediately, with no further CSR write.
  - Build without `TRAP_IRQ_EN`: irq is ignored.

Source files
------------

// File: rtl/trap_ctrl.sv
// -----------------------------------------------------------------------------
// trap_ctrl
//
// Trap sequencer between the commit boundary (IDU/EXU) and the CSR file's
// exception write ports. It accepts ecall, mret and (optionally) the machine
// timer interrupt when an instruction is at the commit boundary. It then
// raises the mepc/mcause/mstatus write strobes for one cycle and redirects
// the fetch PC through a valid/ready handshake.
//
// Configuration macro: TRAP_IRQ_EN
//   defined   - the timer interrupt path (i_irq qualified by mstatus.MIE) is
//               compiled in.
//   undefined - i_irq is unused, only ecall/mret are recognised, and the
//               mcause MSB is always 0.
//
// Parameters
//   ECALL_CAUSE     mcause value written for an M-mode ecall
//   IRQ_CAUSE       interrupt code; mcause = {1'b1, IRQ_CAUSE[W-2:0]}
//
// Ports
//   i_clk, i_rst_n           clock, asynchronous active-low reset
//   i_valid, i_pc            instruction at the commit boundary and its PC
//   i_ecall, i_mret          decode flags, qualified by i_valid
//   i_irq                    level timer interrupt request
//   i_mtvec/i_mepc/i_mstatus current CSR values
//   o_take                   combinational: instruction consumed by trap/mret
//   o_busy                   sequencer not idle (pipeline holds i_valid low)
//   o_*_wen / o_*_wdata      CSR write strobes and data (WB state only)
//   o_redir_valid/_pc        redirect request to IFU
//   i_redir_ready            IFU accepts the redirect
//
// State table
//   IDLE  | waiting for an event at the commit boundary
//   WB    | one cycle of CSR write strobes
//   REDIR | redirect request held until i_redir_ready
// -----------------------------------------------------------------------------
`ifndef CPU_WIDTH
`define CPU_WIDTH 32
`endif

module trap_ctrl #(
    parameter int ECALL_CAUSE = 11,
    parameter int IRQ_CAUSE   = 7
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_valid,
    input  logic [`CPU_WIDTH-1:0]   i_pc,
    input  logic                    i_ecall,
    input  logic                    i_mret,
    input  logic                    i_irq,
    input  logic [`CPU_WIDTH-1:0]   i_mtvec,
    input  logic [`CPU_WIDTH-1:0]   i_mepc,
    input  logic [`CPU_WIDTH-1:0]   i_mstatus,
    output logic                    o_take,
    output logic                    o_busy,
    output logic                    o_mepc_wen,
    output logic [`CPU_WIDTH-1:0]   o_mepc_wdata,
    output logic                    o_mcause_wen,
    output logic [`CPU_WIDTH-1:0]   o_mcause_wdata,
    output logic                    o_mstatus_wen,
    output logic [`CPU_WIDTH-1:0]   o_mstatus_wdata,
    output logic                    o_redir_valid,
    output logic [`CPU_WIDTH-1:0]   o_redir_pc,
    input  logic                    i_redir_ready
);

    localparam int W = `CPU_WIDTH;

    localparam logic [W-1:0] ECALL_CODE   = W'(ECALL_CAUSE);
    localparam logic [W-1:0] IRQ_CODE     = W'(IRQ_CAUSE);
    localparam logic [W-1:0] ECALL_MCAUSE = {1'b0, ECALL_CODE[W-2:0]};
`ifdef TRAP_IRQ_EN
    localparam logic [W-1:0] IRQ_MCAUSE   = {1'b1, IRQ_CODE[W-2:0]};
`else
    localparam logic [W-1:0] IRQ_MCAUSE   = {1'b0, IRQ_CODE[W-2:0]};
`endif

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WB    = 2'd1,
        S_REDIR = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        K_ECALL = 2'd0,
        K_IRQ   = 2'd1,
        K_MRET  = 2'd2
    } kind_t;

    state_t         state_q, state_d;
    kind_t          kind_q,  kind_d;
    logic [W-1:0]   pc_q,    pc_d;
    logic [W-1:0]   target_q, target_d;

    logic           irq_evt;
    logic           take;
    logic [W-1:0]   trap_target;

`ifdef TRAP_IRQ_EN
    assign irq_evt = i_irq & i_mstatus[3];
    logic unused_bits;
    assign unused_bits = ^i_mtvec[1:0];
`else
    assign irq_evt = 1'b0;
    logic unused_bits;
    assign unused_bits = ^{i_irq, i_mtvec[1:0]};
`endif

    // Direct mode only: the mode bits of mtvec are dropped.
    assign trap_target = {i_mtvec[W-1:2], 2'b00};

    assign take = (state_q == S_IDLE) & i_valid & (irq_evt | i_ecall | i_mret);

    always_comb begin
        state_d  = state_q;
        kind_d   = kind_q;
        pc_d     = pc_q;
        target_d = target_q;
        case (state_q)
            S_IDLE: begin
                if (take) begin
                    state_d = S_WB;
                    pc_d    = i_pc;
                    // Interrupt beats ecall beats mret; ecall also wins an
                    // illegal ecall+mret decode.
                    if (irq_evt) begin
                        kind_d   = K_IRQ;
                        target_d = trap_target;
                    end else if (i_ecall) begin
                        kind_d   = K_ECALL;
                        target_d = trap_target;
                    end else begin
                        kind_d   = K_MRET;
                        target_d = i_mepc;
                    end
                end
            end
            S_WB: begin
                state_d = S_REDIR;
            end
            S_REDIR: begin
                if (i_redir_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            kind_q   <= K_ECALL;
            pc_q     <= '0;
            target_q <= '0;
        end else begin
            state_q  <= state_d;
            kind_q   <= kind_d;
            pc_q     <= pc_d;
            target_q <= target_d;
        end
    end

    logic in_wb;
    logic is_trap;
    logic [W-1:0] ms_trap;
    logic [W-1:0] ms_mret;

    assign in_wb   = (state_q == S_WB);
    assign is_trap = (kind_q != K_MRET);

    // mstatus update uses the live CSR value in the WB cycle.
    always_comb begin
        ms_trap        = i_mstatus;
        ms_trap[7]     = i_mstatus[3];
        ms_trap[3]     = 1'b0;
        ms_trap[12:11] = 2'b11;

        ms_mret        = i_mstatus;
        ms_mret[3]     = i_mstatus[7];
        ms_mret[7]     = 1'b1;
        ms_mret[12:11] = 2'b11;
    end

    assign o_take          = take;
    assign o_busy          = (state_q != S_IDLE);

    assign o_mepc_wen      = in_wb & is_trap;
    assign o_mepc_wdata    = o_mepc_wen ? pc_q : '0;

    assign o_mcause_wen    = in_wb & is_trap;
    assign o_mcause_wdata  = !o_mcause_wen       ? '0         :
                             (kind_q == K_IRQ)   ? IRQ_MCAUSE : ECALL_MCAUSE;

    assign o_mstatus_wen   = in_wb;
    assign o_mstatus_wdata = !in_wb ? '0 : (is_trap ? ms_trap : ms_mret);

    assign o_redir_valid   = (state_q == S_REDIR);
    assign o_redir_pc      = o_redir_valid ? target_q : '0;

endmodule

// File: tb/tb_trap_ctrl.sv
module tb_trap_ctrl;

`ifdef TRAP_IRQ_EN
    localparam bit IRQ_ON = 1'b1;
`else
    localparam bit IRQ_ON = 1'b0;
`endif

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid;
    logic [31:0] i_pc;
    logic        i_ecall;
    logic        i_mret;
    logic        i_irq;
    logic [31:0] i_mtvec;
    logic [31:0] i_mepc;
    logic [31:0] i_mstatus;
    logic        o_take;
    logic        o_busy;
    logic        o_mepc_wen;
    logic [31:0] o_mepc_wdata;
    logic        o_mcause_wen;
    logic [31:0] o_mcause_wdata;
    logic        o_mstatus_wen;
    logic [31:0] o_mstatus_wdata;
    logic        o_redir_valid;
    logic [31:0] o_redir_pc;
    logic        i_redir_ready;

    int checks = 0;
    int errors = 0;

    always #5 i_clk = ~i_clk;

    trap_ctrl dut (
        .i_clk           (i_clk),
        .i_rst_n         (i_rst_n),
        .i_valid         (i_valid),
        .i_pc            (i_pc),
        .i_ecall         (i_ecall),
        .i_mret          (i_mret),
        .i_irq           (i_irq),
        .i_mtvec         (i_mtvec),
        .i_mepc          (i_mepc),
        .i_mstatus       (i_mstatus),
        .o_take          (o_take),
        .o_busy          (o_busy),
        .o_mepc_wen      (o_mepc_wen),
        .o_mepc_wdata    (o_mepc_wdata),
        .o_mcause_wen    (o_mcause_wen),
        .o_mcause_wdata  (o_mcause_wdata),
        .o_mstatus_wen   (o_mstatus_wen),
        .o_mstatus_wdata (o_mstatus_wdata),
        .o_redir_valid   (o_redir_valid),
        .o_redir_pc      (o_redir_pc),
        .i_redir_ready   (i_redir_ready)
    );

    typedef struct {
        string       name;
        logic        valid, ecall, mret, irq;
        logic [31:0] pc, mtvec, mepc, mstatus;
        logic        take, mepc_wen, mcause_wen;
        logic [31:0] e_mepc, e_mcause, e_mstatus, e_redir;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Advance one full clock and land on the next falling edge.
    task automatic step();
        @(negedge i_clk);
    endtask

    task automatic idle_inputs();
        i_valid = 1'b0; i_ecall = 1'b0; i_mret = 1'b0;
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, " mepc_wen"},    32'(o_mepc_wen),    32'd0);
        chk({tag, " mcause_wen"},  32'(o_mcause_wen),  32'd0);
        chk({tag, " mstatus_wen"}, 32'(o_mstatus_wen), 32'd0);
        chk({tag, " redir_valid"}, 32'(o_redir_valid), 32'd0);
        chk({tag, " busy"},        32'(o_busy),        32'd0);
    endtask

    task automatic mk(input int i, input string n, input logic v, input logic e,
                      input logic m, input logic q, input logic [31:0] pc,
                      input logic [31:0] tv, input logic [31:0] ep, input logic [31:0] ms,
                      input logic tk, input logic mw, input logic cw,
                      input logic [31:0] xe, input logic [31:0] xc,
                      input logic [31:0] xs, input logic [31:0] xr);
        vecs[i].name = n;   vecs[i].valid = v; vecs[i].ecall = e; vecs[i].mret = m;
        vecs[i].irq = q;    vecs[i].pc = pc;   vecs[i].mtvec = tv; vecs[i].mepc = ep;
        vecs[i].mstatus = ms; vecs[i].take = tk; vecs[i].mepc_wen = mw;
        vecs[i].mcause_wen = cw; vecs[i].e_mepc = xe; vecs[i].e_mcause = xc;
        vecs[i].e_mstatus = xs; vecs[i].e_redir = xr;
    endtask

    task automatic run_vec(input vec_t v);
        i_valid = v.valid; i_ecall = v.ecall; i_mret = v.mret; i_irq = v.irq;
        i_pc = v.pc; i_mtvec = v.mtvec; i_mepc = v.mepc; i_mstatus = v.mstatus;
        i_redir_ready = 1'b1;
        #1;
        chk({v.name, " take"}, 32'(o_take), 32'(v.take));
        step();
        idle_inputs();
        if (v.take) begin
            chk({v.name, " wb busy"},        32'(o_busy),        32'd1);
            chk({v.name, " wb mepc_wen"},    32'(o_mepc_wen),    32'(v.mepc_wen));
            chk({v.name, " wb mcause_wen"},  32'(o_mcause_wen),  32'(v.mcause_wen));
            chk({v.name, " wb mstatus_wen"}, 32'(o_mstatus_wen), 32'd1);
            chk({v.name, " wb mstatus"},     o_mstatus_wdata,    v.e_mstatus);
            chk({v.name, " wb redir_valid"}, 32'(o_redir_valid), 32'd0);
            if (v.mepc_wen) begin
                chk({v.name, " wb mepc"},   o_mepc_wdata,   v.e_mepc);
                chk({v.name, " wb mcause"}, o_mcause_wdata, v.e_mcause);
            end
            step();
            chk({v.name, " redir_valid"},    32'(o_redir_valid), 32'd1);
            chk({v.name, " redir_pc"},       o_redir_pc,         v.e_redir);
            chk({v.name, " redir mstatus_wen"}, 32'(o_mstatus_wen), 32'd0);
            step();
            chk_quiet({v.name, " done"});
        end else begin
            chk_quiet({v.name, " no-take"});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t required below 200000", $time);
        $fatal(1);
    end

    initial begin
        mk(0, "ecall", 1,1,0,0, 32'h8000_0040, 32'h8000_0103, 32'h0, 32'h0000_0008,
           1,1,1, 32'h8000_0040, 32'd11, 32'h0000_1880, 32'h8000_0100);
        mk(1, "mret", 1,0,1,0, 32'h8000_0060, 32'h8000_0103, 32'h8000_0044, 32'h0000_1880,
           1,0,0, 32'h0, 32'h0, 32'h0000_1888, 32'h8000_0044);
        mk(2, "ecall+mret", 1,1,1,0, 32'h8000_0070, 32'h0000_1003, 32'h8000_0044, 32'h0000_1880,
           1,1,1, 32'h8000_0070, 32'd11, 32'h0000_1800, 32'h0000_1000);
        mk(3, "no-event", 1,0,0,0, 32'h8000_0074, 32'h8000_0103, 32'h0, 32'h0000_0008,
           0,0,0, 32'h0, 32'h0, 32'h0, 32'h0);
        mk(4, "ecall-no-valid", 0,1,0,0, 32'h8000_0078, 32'h8000_0103, 32'h0, 32'h0000_0008,
           0,0,0, 32'h0, 32'h0, 32'h0, 32'h0);
        mk(5, "irq-vs-ecall", 1,1,0,1, 32'h8000_0050, 32'h8000_0103, 32'h0, 32'h0000_0008,
           1,1,1, 32'h8000_0050, IRQ_ON ? 32'h8000_0007 : 32'd11, 32'h0000_1880, 32'h8000_0100);
        mk(6, "irq-mie0", 1,0,0,1, 32'h8000_007c, 32'h8000_0103, 32'h0, 32'h0000_1880,
           0,0,0, 32'h0, 32'h0, 32'h0, 32'h0);
        mk(7, "irq-only", 1,0,0,1, 32'h8000_0080, 32'h8000_0202, 32'h0, 32'h0000_0088,
           IRQ_ON,1,1, 32'h8000_0080, 32'h8000_0007, 32'h0000_1880, 32'h8000_0200);
        mk(8, "mret-mpie0", 1,0,1,0, 32'h8000_0084, 32'h8000_0103, 32'h1234_5679, 32'h0,
           1,0,0, 32'h0, 32'h0, 32'h0000_1880, 32'h1234_5679);

        i_rst_n = 1'b0; idle_inputs(); i_irq = 1'b0; i_pc = '0; i_mtvec = '0;
        i_mepc = '0; i_mstatus = '0; i_redir_ready = 1'b0;
        step(); step();
        #1;
        chk_quiet("reset");
        chk("reset take", 32'(o_take), 32'd0);
        chk("reset redir_pc", o_redir_pc, 32'd0);
        chk("reset mstatus_wdata", o_mstatus_wdata, 32'd0);
        step();
        i_rst_n = 1'b1;
        step();

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // IFU backpressure, ignored pulses while busy, then back-to-back event.
        i_valid = 1; i_ecall = 1; i_pc = 32'h8000_0040; i_mtvec = 32'h8000_0103;
        i_mstatus = 32'h8; i_irq = 0; i_redir_ready = 0;
        #1; chk("bp take", 32'(o_take), 32'd1);
        step(); idle_inputs();
        step();
        for (int c = 0; c < 5; c++) begin
            chk("bp redir_valid", 32'(o_redir_valid), 32'd1);
            chk("bp redir_pc", o_redir_pc, 32'h8000_0100);
            chk("bp busy", 32'(o_busy), 32'd1);
            i_valid = 1; i_ecall = 1; i_pc = 32'h9000_0000 + 32'(c);
            #1;
            chk("bp ignored take", 32'(o_take), 32'd0);
            chk("bp no mepc_wen", 32'(o_mepc_wen), 32'd0);
            step(); idle_inputs();
        end
        chk("bp still valid", 32'(o_redir_valid), 32'd1);
        chk("bp pc held", o_redir_pc, 32'h8000_0100);
        i_redir_ready = 1;
        step();
        chk_quiet("bp done");
        i_valid = 1; i_mret = 1; i_mepc = 32'h8000_0044; i_mstatus = 32'h1880;
        #1; chk("b2b take", 32'(o_take), 32'd1);
        step(); idle_inputs();
        chk("b2b mstatus", o_mstatus_wdata, 32'h0000_1888);
        step();
        chk("b2b redir_pc", o_redir_pc, 32'h8000_0044);
        step();
        chk_quiet("b2b done");

        // Interrupt pending while MIE=0, then enabled by mret.
        i_irq = 1; i_mstatus = 32'h0000_0080;
        for (int c = 0; c < 10; c++) begin
            i_valid = 1; i_pc = 32'h8000_1000 + 32'(4 * c);
            #1; chk("mie0 take", 32'(o_take), 32'd0);
            step();
            chk("mie0 mstatus_wen", 32'(o_mstatus_wen), 32'd0);
            chk("mie0 busy", 32'(o_busy), 32'd0);
        end
        i_mret = 1; i_mepc = 32'h8000_0090; i_pc = 32'h8000_1100;
        #1; chk("mie0 mret take", 32'(o_take), 32'd1);
        step(); idle_inputs();
        chk("mie0 mret mstatus", o_mstatus_wdata, 32'h0000_1888);
        chk("mie0 mret mcause_wen", 32'(o_mcause_wen), 32'd0);
        i_mstatus = 32'h0000_1888;
        step();
        chk("mie0 mret redir", o_redir_pc, 32'h8000_0090);
        step();
        i_valid = 1; i_pc = 32'h8000_00a0;
`ifdef TRAP_IRQ_EN
        #1; chk("irq after mret take", 32'(o_take), 32'd1);
        step(); idle_inputs();
        i_irq = 0;
        chk("irq after mret mcause", o_mcause_wdata, 32'h8000_0007);
        chk("irq after mret mepc", o_mepc_wdata, 32'h8000_00a0);
        chk("irq after mret mstatus", o_mstatus_wdata, 32'h0000_1880);
        step();
        chk("irq after mret redir", o_redir_pc, 32'h8000_0100);
        step();
        chk_quiet("irq after mret done");
`else
        #1; chk("irq disabled take", 32'(o_take), 32'd0);
        step(); idle_inputs();
        chk_quiet("irq disabled");
        i_irq = 0;
`endif

        // Reset during WB, then during REDIR.
        for (int r = 0; r < 2; r++) begin
            i_valid = 1; i_ecall = 1; i_pc = 32'h8000_0200; i_mstatus = 32'h8;
            #1; chk("rst take", 32'(o_take), 32'd1);
            step(); idle_inputs();
            if (r == 1) begin
                step();
                chk("rst pre redir_valid", 32'(o_redir_valid), 32'd1);
            end else begin
                chk("rst pre mepc_wen", 32'(o_mepc_wen), 32'd1);
            end
            #2 i_rst_n = 1'b0;
            #1;
            chk_quiet(r == 0 ? "rst in wb" : "rst in redir");
            chk("rst redir_pc", o_redir_pc, 32'd0);
            chk("rst mepc_wdata", o_mepc_wdata, 32'd0);
            step();
            i_rst_n = 1'b1;
            for (int c = 0; c < 3; c++) begin
                step();
                chk_quiet("post rst");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
